// File: rtl/bip_datapath_if.sv
// Control-strobe, data-memory and status bundle between the BIP control unit and its datapath.
// BIP_OVF_FLAG_EN adds the sticky signed-overflow status bit o_overflow.
interface bip_datapath_if #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned ADDRESS_BITS = 11,
  parameter int unsigned CYCLE_BITS   = 32
);
  logic [ADDRESS_BITS-1:0] i_operand;
  logic [1:0]              i_sel_a;
  logic                    i_sel_b;
  logic                    i_write_acc;
  logic                    i_operation;
  logic                    i_write_mem;
  logic                    i_read_mem;
  logic                    i_done;
  logic [DATA_BITS-1:0]    i_mem_rdata;
  logic [ADDRESS_BITS-1:0] o_mem_addr;
  logic [DATA_BITS-1:0]    o_mem_wdata;
  logic                    o_mem_we;
  logic                    o_mem_re;
  logic [DATA_BITS-1:0]    o_acc;
  logic                    o_halted;
  logic [CYCLE_BITS-1:0]   o_cycles;
`ifdef BIP_OVF_FLAG_EN
  logic                    o_overflow;

  modport master (
    output i_operand, i_sel_a, i_sel_b, i_write_acc, i_operation, i_write_mem, i_read_mem,
    output i_done, i_mem_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_acc, o_halted, o_cycles, o_overflow
  );

  modport slave (
    input  i_operand, i_sel_a, i_sel_b, i_write_acc, i_operation, i_write_mem, i_read_mem,
    input  i_done, i_mem_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_acc, o_halted, o_cycles, o_overflow
  );
`else
  modport master (
    output i_operand, i_sel_a, i_sel_b, i_write_acc, i_operation, i_write_mem, i_read_mem,
    output i_done, i_mem_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_acc, o_halted, o_cycles
  );

  modport slave (
    input  i_operand, i_sel_a, i_sel_b, i_write_acc, i_operation, i_write_mem, i_read_mem,
    input  i_done, i_mem_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_acc, o_halted, o_cycles
  );
`endif
endinterface

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, 16-bit add/sub ALU, data-memory port, halt flag, cycle count.
// Optional BIP_OVF_FLAG_EN builds a sticky signed-overflow flag on ALU writes to the accumulator.
module bip_datapath #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned ADDRESS_BITS = 11,
  parameter int unsigned CYCLE_BITS   = 32
) (
  input logic            clk,
  input logic            rst,
  bip_datapath_if.slave  dp
);

  logic [DATA_BITS-1:0]  acc_q;
  logic                  halted_q;
  logic [CYCLE_BITS-1:0] cycles_q;
  logic [DATA_BITS-1:0]  imm_ext;
  logic [DATA_BITS-1:0]  alu_b;
  logic [DATA_BITS-1:0]  alu_res;
  logic [DATA_BITS-1:0]  acc_d;
  logic                  acc_we;

  assign imm_ext = {{(DATA_BITS - ADDRESS_BITS){dp.i_operand[ADDRESS_BITS-1]}}, dp.i_operand};

  always_comb begin
    alu_b   = dp.i_sel_b ? imm_ext : dp.i_mem_rdata;
    alu_res = dp.i_operation ? (acc_q - alu_b) : (acc_q + alu_b);
    acc_d   = acc_q;
    unique case (dp.i_sel_a)
      2'd0:    acc_d = dp.i_mem_rdata;
      2'd1:    acc_d = imm_ext;
      2'd2:    acc_d = alu_res;
      default: acc_d = acc_q;
    endcase
  end

  assign acc_we = dp.i_write_acc & ~halted_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q    <= '0;
      halted_q <= 1'b0;
      cycles_q <= '0;
    end else if (!halted_q) begin
      if (acc_we) acc_q <= acc_d;
      if (dp.i_done) halted_q <= 1'b1;
      // Counts the HLT posedge too, then freezes; saturates instead of wrapping.
      if (cycles_q != {CYCLE_BITS{1'b1}}) cycles_q <= cycles_q + CYCLE_BITS'(1);
    end
  end

`ifdef BIP_OVF_FLAG_EN
  logic ovf_q;
  logic ovf_now;

  always_comb begin
    if (dp.i_operation) begin
      ovf_now = (acc_q[DATA_BITS-1] != alu_b[DATA_BITS-1]) &&
                (alu_res[DATA_BITS-1] != acc_q[DATA_BITS-1]);
    end else begin
      ovf_now = (acc_q[DATA_BITS-1] == alu_b[DATA_BITS-1]) &&
                (alu_res[DATA_BITS-1] != acc_q[DATA_BITS-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (acc_we && dp.i_sel_a == 2'd2 && ovf_now) begin
      ovf_q <= 1'b1;
    end
  end

  assign dp.o_overflow = ovf_q;
`endif

  // Store sees the pre-update accumulator, so store-then-load in one cycle works.
  assign dp.o_mem_addr  = dp.i_operand;
  assign dp.o_mem_wdata = acc_q;
  assign dp.o_mem_we    = dp.i_write_mem & ~halted_q;
  assign dp.o_mem_re    = dp.i_read_mem & ~halted_q;
  assign dp.o_acc       = acc_q;
  assign dp.o_halted    = halted_q;
  assign dp.o_cycles    = cycles_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath: loads, ALU ops, wrap, store/load ordering, halt and reset.
module tb_bip_datapath;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bip_datapath_if #(.DATA_BITS(16), .ADDRESS_BITS(11), .CYCLE_BITS(32)) bus ();

  bip_datapath #(.DATA_BITS(16), .ADDRESS_BITS(11), .CYCLE_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                       input logic wm, input logic rm, input logic dn,
                       input logic [10:0] opnd, input logic [15:0] rd);
    bus.i_sel_a     = sa;
    bus.i_sel_b     = sb;
    bus.i_write_acc = wa;
    bus.i_operation = op;
    bus.i_write_mem = wm;
    bus.i_read_mem  = rm;
    bus.i_done      = dn;
    bus.i_operand   = opnd;
    bus.i_mem_rdata = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);

    // Reset with random strobes
    for (int i = 0; i < 3; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 11'($urandom), 16'($urandom));
      tick();
    end
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    check("rst_acc", 32'(bus.o_acc), 32'h0);
    check("rst_halted", 32'(bus.o_halted), 32'h0);
    check("rst_cycles", bus.o_cycles, 32'h0);
    check("rst_we", 32'(bus.o_mem_we), 32'h0);
    check("rst_re", 32'(bus.o_mem_re), 32'h0);
`ifdef BIP_OVF_FLAG_EN
    check("rst_ovf", 32'(bus.o_overflow), 32'h0);
`endif
    rst = 1'b1;

    // LDI 0x005
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h005, 16'h0000);
    tick();
    check("ldi_acc", 32'(bus.o_acc), 32'h0005);
    // ADDI 0x7FF (-1)
    drive(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h7FF, 16'h0000);
    tick();
    check("addi_acc", 32'(bus.o_acc), 32'h0004);
    // STO 0x010
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h010, 16'h0000);
    check("sto_we", 32'(bus.o_mem_we), 32'h1);
    check("sto_addr", 32'(bus.o_mem_addr), 32'h010);
    check("sto_wdata", 32'(bus.o_mem_wdata), 32'h0004);
    tick();
    check("sto_acc_hold", 32'(bus.o_acc), 32'h0004);
    // LD 0x020 = 0x1234
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h020, 16'h1234);
    check("ld_re", 32'(bus.o_mem_re), 32'h1);
    check("ld_addr", 32'(bus.o_mem_addr), 32'h020);
    tick();
    check("ld_acc", 32'(bus.o_acc), 32'h1234);
    // SUB 0x021 = 0x0234
    drive(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'h021, 16'h0234);
    check("sub_re", 32'(bus.o_mem_re), 32'h1);
    tick();
    check("sub_acc", 32'(bus.o_acc), 32'h1000);
    // LDI 0, SUBI 1 -> 0xFFFF, no signed overflow
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    tick();
    check("ldi0_acc", 32'(bus.o_acc), 32'h0000);
    drive(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001, 16'h0000);
    tick();
    check("subi_wrap_acc", 32'(bus.o_acc), 32'hFFFF);
`ifdef BIP_OVF_FLAG_EN
    check("subi_no_ovf", 32'(bus.o_overflow), 32'h0);
`endif
    // LD 0x7FFF, ADDI 1 -> 0x8000, signed overflow
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h030, 16'h7FFF);
    tick();
    check("ld7fff_acc", 32'(bus.o_acc), 32'h7FFF);
    drive(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 16'h0000);
    tick();
    check("addi_wrap_acc", 32'(bus.o_acc), 32'h8000);
`ifdef BIP_OVF_FLAG_EN
    check("addi_ovf", 32'(bus.o_overflow), 32'h1);
`endif
    // Store and load in the same cycle
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0AA, 16'h0000);
    tick();
    check("ldi_aa_acc", 32'(bus.o_acc), 32'h00AA);
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'h040, 16'h0055);
    check("stld_we", 32'(bus.o_mem_we), 32'h1);
    check("stld_wdata", 32'(bus.o_mem_wdata), 32'h00AA);
    tick();
    check("stld_acc", 32'(bus.o_acc), 32'h0055);
    check("run_cycles", bus.o_cycles, 32'd11);
    check("run_halted", 32'(bus.o_halted), 32'h0);

    // Reset pulse, then 4 instructions and HLT
    rst = 1'b0;
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    tick();
    rst = 1'b1;
    check("rst2_cycles", bus.o_cycles, 32'h0);
    check("rst2_acc", 32'(bus.o_acc), 32'h0);
`ifdef BIP_OVF_FLAG_EN
    check("rst2_ovf", 32'(bus.o_overflow), 32'h0);
`endif
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 16'h0000);
    tick();
    drive(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 16'h0000);
    tick();
    drive(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001, 16'h0000);
    tick();
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h050, 16'h0000);
    tick();
    check("pre_hlt_acc", 32'(bus.o_acc), 32'h0003);
    check("pre_hlt_cycles", bus.o_cycles, 32'd4);
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 16'h0000);
    tick();
    check("hlt_halted", 32'(bus.o_halted), 32'h1);
    check("hlt_cycles", bus.o_cycles, 32'd5);
    // Strobes while halted are ignored
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'h123, 16'hBEEF);
    check("halt_we", 32'(bus.o_mem_we), 32'h0);
    check("halt_re", 32'(bus.o_mem_re), 32'h0);
    tick();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'h124, 16'hBEEF);
    tick();
    check("halt_acc", 32'(bus.o_acc), 32'h0003);
    check("halt_cycles", bus.o_cycles, 32'd5);
    check("halt_sticky", 32'(bus.o_halted), 32'h1);

    // Reset clears halt and the counter restarts
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000);
    check("rst3_halted", 32'(bus.o_halted), 32'h0);
    check("rst3_acc", 32'(bus.o_acc), 32'h0);
    check("rst3_cycles", bus.o_cycles, 32'h0);
    tick();
    check("restart_cycles", bus.o_cycles, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
Execution datapath of the BIP core. It sits directly downstream of the control unit and consumes its operand and control strobes: sel_a, sel_b, write_acc, operation, write_mem, read_mem and done. It holds the accumulator, performs 16-bit add/sub on memory or immediate operands, and drives the data-memory port. It also keeps a sticky done flag and a cycle counter, which the debug/readout logic uses.

Parameters:
DATA_BITS, 16, accumulator / ALU / data-memory word width
ADDRESS_BITS, 11, operand field width and data-memory address width
CYCLE_BITS, 32, width of the executed-cycle counter

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  reset, synchronous, active-low
i_operand  input  ADDRESS_BITS  instruction operand (address or immediate)
i_sel_a  input  2  accumulator source: 0 = data memory, 1 = sign-extended immediate, 2 = ALU result, 3 = hold
i_sel_b  input  1  ALU B source: 0 = data memory, 1 = sign-extended immediate
i_write_acc  input  1  load accumulator from sel_a mux
i_operation  input  1  ALU op: 0 = A+B, 1 = A-B (A = accumulator)
i_write_mem  input  1  store accumulator to data memory
i_read_mem  input  1  data-memory read request
i_done  input  1  HLT decoded
i_mem_rdata  input  DATA_BITS  data-memory read word; valid at posedge following a read request
o_mem_addr  output  ADDRESS_BITS  data-memory address = i_operand, combinational
o_mem_wdata  output  DATA_BITS  = accumulator, combinational
o_mem_we  output  1  write enable
o_mem_re  output  1  read enable
o_acc  output  DATA_BITS  accumulator value
o_halted  output  1  sticky halt flag
o_cycles  output  CYCLE_BITS  posedges executed since reset, up to and including the HLT cycle

Behaviour:
- Reset (rst=0 at posedge): acc=0, o_halted=0, o_cycles=0. Overflow flag (if built) = 0. Reset mid-program takes priority over every other input.
- Immediate extension: the operand is sign-extended from bit ADDRESS_BITS-1 to DATA_BITS. Example: 0x7FF becomes 0xFFFF; 0x3FF becomes 0x03FF.
- ALU is combinational: result = acc + B or acc - B, modulo 2^DATA_BITS. Wrap-around is silent: 0x7FFF + 1 = 0x8000; 0x0000 - 1 = 0xFFFF.
- Accumulator:
  - On posedge with write_acc=1 and halted=0, acc <= mux(sel_a).
  - sel_a=3 or write_acc=0 holds the value.
  - Memory-sourced loads use i_mem_rdata sampled at that same posedge.
- Memory strobes:
  - o_mem_we = i_write_mem & ~o_halted; o_mem_re = i_read_mem & ~o_halted.
  - Both are combinational so the memory sees them within the same instruction cycle.
  - If write_mem and write_acc are both 1, memory receives the pre-update acc value (store-then-load ordering).
- Halt:
  - At the first posedge with i_done=1, o_halted <= 1.
  - Once set, o_halted stays set until reset.
  - While halted, acc is frozen and both memory strobes are forced to 0, regardless of inputs.
- Cycle counter:
  - Increments on every posedge while o_halted=0, including the posedge that sets halted.
  - Saturates at all-ones and does not wrap.
- Pipeline latency: control strobes at cycle N affect acc at posedge N. o_acc reflects the new value after posedge N.

Optional Feature:
BIP_OVF_FLAG_EN:
- When defined, adds output o_overflow (1 bit), a sticky signed-overflow flag.
- Set on posedge when write_acc=1, sel_a=2, halted=0, and the signed result overflows:
  - add: operands share a sign and the result sign differs;
  - sub: operands differ in sign and the result sign differs from acc.
- Cleared only by reset.
- When not defined, the port is absent and no overflow logic is built.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random strobes -> acc=0, halted=0, cycles=0, we=re=0 after reset.
- LDI 0x005, ADDI 0x7FF (sel_b=1, op=0) -> acc=0x0005 then 0x0004. STO to addr 0x010 -> mem_we=1, addr=0x010, wdata=0x0004.
- LD from addr 0x020 holding 0x1234, then SUB addr 0x021 holding 0x0234 -> acc=0x1234 then 0x1000; mem_re asserted both cycles.
- Wrap: acc=0x7FFF, ADDI 1 -> acc=0x8000 (o_overflow=1 with BIP_OVF_FLAG_EN). acc=0x0000, SUBI 1 -> acc=0xFFFF, no overflow.
- Halt: 4 instructions then i_done=1, then further write_acc/write_mem strobes -> cycles=5 and frozen, acc unchanged, we=re=0. Pulse rst=0 -> all cleared and the counter restarts.
- Simultaneous write_mem+write_acc with acc=0x00AA, mem-load 0x0055 -> wdata=0x00AA, acc=0x0055 next cycle.
